alu_seq: RTL



---
 rtl/common.sv | 30 +++
 rtl/alu_shift_unit.sv | 82 ++++++++
 rtl/alu_seq.sv | 116 +++++++++++
 3 files changed

// File: rtl/common.sv
// ============================================================================
// Module : common (package)
// Brief  : Shared ALU opcode and sequencer state encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package common;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [0:0] {
        ALU_IDLE  = 1'b0,
        ALU_SHIFT = 1'b1
    } alu_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_shift_unit.sv
// ============================================================================
// Module : alu_shift_unit
// Brief  : Shifter for alu_seq: iterative 1-bit/cycle or single-cycle barrel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_shift_unit
    import common::*;
#(
    parameter int XLEN         = 32,
    parameter int SERIAL_SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  alu_op_t                  i_op,
    input  logic [XLEN-1:0]          i_data,
    input  logic [$clog2(XLEN)-1:0]  i_shamt,
    input  logic                     i_out_free,
    output logic                     o_done,
    output logic [XLEN-1:0]          o_result
);

    localparam int c_SW = $clog2(XLEN);

    generate
        if (SERIAL_SHIFT != 0) begin : g_serial
            logic [XLEN-1:0] r_work;
            logic [c_SW-1:0] r_count;
            alu_op_t         r_op;
            logic [XLEN-1:0] w_step;

            always_comb begin
                case (r_op)
                    ALU_SLL: w_step = {r_work[XLEN-2:0], 1'b0};
                    ALU_SRL: w_step = {1'b0, r_work[XLEN-1:1]};
                    default: w_step = {r_work[XLEN-1], r_work[XLEN-1:1]};
                endcase
            end

            // The last step only advances once the output register can take it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_work  <= '0;
                    r_count <= '0;
                    r_op    <= ALU_ADD;
                end else if (i_start) begin
                    r_work  <= i_data;
                    r_count <= i_shamt;
                    r_op    <= i_op;
                end else if (r_count > c_SW'(1)) begin
                    r_work  <= w_step;
                    r_count <= r_count - c_SW'(1);
                end else if ((r_count == c_SW'(1)) && i_out_free) begin
                    r_work  <= w_step;
                    r_count <= '0;
                end
            end

            assign o_done   = (r_count == c_SW'(1)) && i_out_free;
            assign o_result = w_step;
        end else begin : g_barrel
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, i_start, i_out_free};

            always_comb begin
                case (i_op)
                    ALU_SLL: o_result = i_data << i_shamt;
                    ALU_SRL: o_result = i_data >> i_shamt;
                    ALU_SRA: o_result = XLEN'($signed(i_data) >>> i_shamt);
                    default: o_result = i_data;
                endcase
            end

            assign o_done = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module : alu_seq
// Brief  : Handshaked ALU with registered result/zero flag and optional serial shifter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq
    import common::*;
#(
    parameter int XLEN         = 32,
    parameter int SERIAL_SHIFT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  alu_op_t         control,
    input  logic [XLEN-1:0] left_operand,
    input  logic [XLEN-1:0] right_operand,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            ZeroFlag
);

    localparam int c_SW = $clog2(XLEN);

    alu_seq_state_t  r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic            r_zero;

    logic [c_SW-1:0] w_shamt;
    logic            w_is_shift;
    logic            w_out_free;
    logic            w_accept;
    logic            w_serial_start;
    logic            w_shift_done;
    logic [XLEN-1:0] w_shift_res;
    logic [XLEN-1:0] w_alu;
    logic            w_write;
    logic [XLEN-1:0] w_wdata;

    assign w_shamt        = right_operand[c_SW-1:0];
    assign w_is_shift     = control inside {ALU_SLL, ALU_SRL, ALU_SRA};
    assign w_out_free     = !r_out_valid || out_ready;
    assign in_ready       = (r_state == ALU_IDLE) && w_out_free;
    assign w_accept       = in_valid && in_ready;
    assign w_serial_start = (SERIAL_SHIFT != 0) && w_accept && w_is_shift && (w_shamt != '0);

    alu_shift_unit #(
        .XLEN         (XLEN),
        .SERIAL_SHIFT (SERIAL_SHIFT)
    ) u_shift (
        .clk        (clk),
        .rst        (reset),
        .i_start    (w_serial_start),
        .i_op       (control),
        .i_data     (left_operand),
        .i_shamt    (w_shamt),
        .i_out_free (w_out_free),
        .o_done     (w_shift_done),
        .o_result   (w_shift_res)
    );

    // In serial mode a shift only reaches this mux when its amount is zero.
    always_comb begin
        case (control)
            ALU_ADD:  w_alu = left_operand + right_operand;
            ALU_SUB:  w_alu = left_operand - right_operand;
            ALU_AND:  w_alu = left_operand & right_operand;
            ALU_OR:   w_alu = left_operand | right_operand;
            ALU_XOR:  w_alu = left_operand ^ right_operand;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  w_alu = (SERIAL_SHIFT != 0) ? left_operand : w_shift_res;
            ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(left_operand) < $signed(right_operand)};
            ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, left_operand < right_operand};
            default:  w_alu = left_operand + right_operand;
        endcase
    end

    assign w_write = (r_state == ALU_IDLE) ? (w_accept && !w_serial_start) : w_shift_done;
    assign w_wdata = (r_state == ALU_SHIFT) ? w_shift_res : w_alu;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ALU_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                ALU_IDLE:  if (w_serial_start) r_state <= ALU_SHIFT;
                ALU_SHIFT: if (w_shift_done)   r_state <= ALU_IDLE;
                default:                       r_state <= ALU_IDLE;
            endcase

            if (w_write) begin
                r_out_valid <= 1'b1;
                r_result    <= w_wdata;
                r_zero      <= (w_wdata == '0);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign ZeroFlag  = r_zero;

endmodule

`default_nettype wire
